alu_pipe: RTL

//  Parametrised, registered successor of the 4-bit combinational ALU: WIDTH-bit operands,
//  8 operations, status flags and valid/ready handshakes on input and output.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_seq.sv | 67 ++++++
 rtl/alu_pipe.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag layout and control states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic c;
    logic z;
  } alu_flags_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: WIDTH steps per product, product held stable until next start.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;

  assign done_o    = busy_q && (cnt_q == CW'(WIDTH));
  assign busy_o    = busy_q;
  assign product_o = acc_q;

  // The first partial product is folded into the start cycle so the
  // product is final WIDTH-1 edges after start.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start_i) begin
      acc_d    = b_i[0] ? {{WIDTH{1'b0}}, a_i} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a_i, 1'b0};
      mplier_d = b_i >> 1;
      cnt_d    = CW'(1);
      busy_d   = 1'b1;
    end else if (done_o) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered WIDTH-bit ALU with valid/ready on both sides; MUL runs on the sequential multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int unsigned SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  alu_state_e          state_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    result_q;
  alu_flags_t          flags_q;

  alu_op_e             op;
  logic                slot_free, accept, beat, mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0]  mul_prod;
  logic [WIDTH:0]      wide;
  logic [WIDTH-1:0]    alu_res;
  alu_flags_t          alu_flg, mul_flg;
  logic [SW-1:0]       amt;

  assign op        = alu_op_e'(opcode);
  assign amt       = b[SW-1:0];
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == S_IDLE) && !mul_busy && slot_free;
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid_q && out_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_flg = '0;
    case (op)
      OP_ADD: begin
        wide      = {1'b0, a} + {1'b0, b};
        alu_res   = wide[WIDTH-1:0];
        alu_flg.c = wide[WIDTH];
        alu_flg.v = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        wide      = {1'b0, a} - {1'b0, b};
        alu_res   = wide[WIDTH-1:0];
        alu_flg.c = !wide[WIDTH];
        alu_flg.v = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        wide      = {1'b0, a} << amt;
        alu_res   = wide[WIDTH-1:0];
        alu_flg.c = wide[WIDTH];
      end
      OP_SHR: begin
        wide      = {a, 1'b0} >> amt;
        alu_res   = wide[WIDTH:1];
        alu_flg.c = wide[0];
      end
      default: ;
    endcase
    alu_flg.n = alu_res[WIDTH-1];
    alu_flg.z = (alu_res == '0);
  end

  always_comb begin
    mul_flg   = '0;
    mul_flg.n = mul_prod[WIDTH-1];
    mul_flg.v = |mul_prod[2*WIDTH-1:WIDTH];
    mul_flg.z = (mul_prod[WIDTH-1:0] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      if (beat) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q <= S_MUL;
            end else begin
              result_q    <= alu_res;
              flags_q     <= alu_flg;
              out_valid_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            if (slot_free) begin
              result_q    <= mul_prod[WIDTH-1:0];
              flags_q     <= mul_flg;
              out_valid_q <= 1'b1;
              state_q     <= S_IDLE;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (beat) begin
            result_q    <= mul_prod[WIDTH-1:0];
            flags_q     <= mul_flg;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
